// File: rtl/lsu_mem.sv
// Load/store unit for the MEM stage: issues one outstanding data-bus access,
// formats load data, stalls the pipeline while busy, and reports misaligned
// accesses and bus timeouts.
module lsu_mem #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_rmem,
  input  logic              mem_wmem,
  input  logic [2:0]        mem_funct3,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              stall_req,
  output logic              misalign,
  output logic              bus_err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [31:0]       bus_rdata
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t           state, state_nxt;
  logic             req_any, aligned, done_ok, tmo;
  logic [3:0]       be_nxt;
  logic [31:0]      wdata_nxt, load_fmt;
  logic [2:0]       f3_q;
  logic [1:0]       lo_q;
  logic [CNT_W-1:0] cnt;

  // Decode access size from funct3[1:0]: alignment, lane enables, replicated data
  always_comb begin
    req_any   = mem_rmem | mem_wmem;
    aligned   = 1'b1;
    be_nxt    = 4'b1111;
    wdata_nxt = mem_wdata;
    case (mem_funct3[1:0])
      2'b00: begin
        be_nxt    = 4'b0001 << mem_addr[1:0];
        wdata_nxt = {4{mem_wdata[7:0]}};
      end
      2'b01: begin
        aligned   = ~mem_addr[0];
        be_nxt    = mem_addr[1] ? 4'b1100 : 4'b0011;
        wdata_nxt = {2{mem_wdata[15:0]}};
      end
      default: aligned = (mem_addr[1:0] == 2'b00);
    endcase
    // Loads always fetch the whole word; lane selection happens on return
    if (!mem_wmem) be_nxt = 4'b1111;
  end

  // Completion and timeout conditions for the in-flight access
  always_comb begin
    done_ok = ((state == S_REQ) && bus_gnt && bus_rvalid) ||
              ((state == S_WAIT) && bus_rvalid);
    tmo     = ((state == S_REQ) || (state == S_WAIT)) &&
              (cnt == CNT_W'(TIMEOUT - 1)) && !done_ok;
  end

  // Next-state logic and handshake/status outputs
  always_comb begin
    state_nxt = state;
    stall_req = 1'b0;
    bus_req   = 1'b0;
    bus_err   = tmo;
    misalign  = (state == S_IDLE) && req_any && !aligned && !rst;
    case (state)
      S_IDLE: begin
        if (req_any && aligned) begin
          stall_req = 1'b1;
          state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        bus_req   = 1'b1;
        stall_req = 1'b1;
        if (done_ok || tmo) state_nxt = S_DONE;
        else if (bus_gnt)   state_nxt = S_WAIT;
      end
      S_WAIT: begin
        stall_req = 1'b1;
        if (done_ok || tmo) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Timeout counter: zero in IDLE/DONE, counts every REQ/WAIT cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                       cnt <= '0;
    else if ((state == S_REQ) || (state == S_WAIT)) cnt <= cnt + 1'b1;
    else                                           cnt <= '0;
  end

  // Latch the bus request fields when an aligned access is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
      f3_q      <= '0;
      lo_q      <= '0;
    end else if ((state == S_IDLE) && req_any && aligned) begin
      bus_we    <= mem_wmem;
      bus_addr  <= {mem_addr[ADDR_W-1:2], 2'b00};
      bus_be    <= be_nxt;
      bus_wdata <= wdata_nxt;
      f3_q      <= mem_funct3;
      lo_q      <= mem_addr[1:0];
    end
  end

  // Select the addressed byte/half of the returned word and extend it
  always_comb begin
    load_fmt = bus_rdata;
    case (f3_q)
      3'b000, 3'b100: begin
        load_fmt[7:0]  = bus_rdata[8*lo_q +: 8];
        load_fmt[31:8] = {24{bus_rdata[8*lo_q + 7] & ~f3_q[2]}};
      end
      3'b001, 3'b101: begin
        load_fmt[15:0]  = lo_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        load_fmt[31:16] = {16{(lo_q[1] ? bus_rdata[31] : bus_rdata[15]) & ~f3_q[2]}};
      end
      default: load_fmt = bus_rdata;
    endcase
  end

  // Load result register: updates only on load completion or load timeout
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       mem_rdata <= '0;
    else if (done_ok && !bus_we)   mem_rdata <= load_fmt;
    else if (tmo && !bus_we)       mem_rdata <= '0;
  end

endmodule

// File: tb/tb_lsu_mem.sv
// Directed bench for lsu_mem: expected bus transactions and load results are
// queued at issue and checked when the unit requests the bus / completes.
module tb_lsu_mem;
  logic        clk = 1'b0;
  logic        rst;
  logic        mem_rmem, mem_wmem;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata;
  logic        stall_req, misalign, bus_err, bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt, bus_rvalid;
  logic [31:0] bus_rdata;

  lsu_mem #(.ADDR_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .mem_rmem(mem_rmem), .mem_wmem(mem_wmem), .mem_funct3(mem_funct3),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stall_req(stall_req), .misalign(misalign), .bus_err(bus_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  txn_t        sb[$];
  logic [31:0] exp_rd;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    mem_rmem = 1'b0; mem_wmem = 1'b0; mem_funct3 = 3'b000;
    mem_addr = '0;   mem_wdata = '0;
  endtask

  // One complete access: g cycles before gnt, rvalid r cycles after gnt (0 = same cycle)
  task automatic do_access(input logic rm, input logic wm, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input int g, input int r, input logic [31:0] word,
                           input logic [31:0] e_addr, input logic [3:0] e_be,
                           input logic [31:0] e_wd, input logic [31:0] e_rd);
    txn_t t;
    int   stall_n = 0;
    mem_rmem = rm; mem_wmem = wm; mem_funct3 = f3; mem_addr = addr; mem_wdata = wd;
    bus_rdata = word;
    t.addr = e_addr; t.be = e_be; t.we = wm; t.wdata = e_wd; t.rdata = e_rd;
    sb.push_back(t);
    #1;
    chk("issue_stall", stall_req, 1);
    chk("issue_misalign", misalign, 0);
    stall_n += int'(stall_req);
    tick();
    for (int i = 0; i <= g; i++) begin
      chk("req_bus_req", bus_req, 1);
      chk("req_addr", bus_addr, sb[0].addr);
      chk("req_be", bus_be, sb[0].be);
      chk("req_we", bus_we, sb[0].we);
      if (sb[0].we) chk("req_wdata", bus_wdata, sb[0].wdata);
      stall_n += int'(stall_req);
      if (i == g) begin
        bus_gnt = 1'b1;
        bus_rvalid = (r == 0);
      end
      tick();
    end
    bus_gnt = 1'b0; bus_rvalid = 1'b0;
    for (int i = 1; i <= r; i++) begin
      chk("wait_bus_req", bus_req, 0);
      stall_n += int'(stall_req);
      if (i == r) bus_rvalid = 1'b1;
      tick();
    end
    bus_rvalid = 1'b0;
    t = sb.pop_front();
    if (!t.we) exp_rd = t.rdata;
    chk("stall_cycles", stall_n, 2 + g + r);
    chk("done_stall", stall_req, 0);
    chk("done_bus_req", bus_req, 0);
    chk("done_rdata", mem_rdata, exp_rd);
    clear_inputs();
    tick();
    chk("idle_bus_req", bus_req, 0);
    chk("idle_stall", stall_req, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    clear_inputs();
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    exp_rd = '0;
    tick(); tick();
    chk("rst_rdata", mem_rdata, 0);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_be", bus_be, 0);
    chk("rst_misalign", misalign, 0);
    chk("rst_bus_err", bus_err, 0);
    rst = 1'b0;
    tick();

    // LB / LBU at 0x1003, top byte 0x80
    do_access(1, 0, 3'b000, 32'h1003, 0, 0, 1, 32'h8000_0000, 32'h1000, 4'hF, 0, 32'hFFFF_FF80);
    do_access(1, 0, 3'b100, 32'h1003, 0, 0, 1, 32'h8000_0000, 32'h1000, 4'hF, 0, 32'h0000_0080);
    // SH at 0x2002 with delayed grant; SB at 0x2001
    do_access(0, 1, 3'b001, 32'h2002, 32'h0000_ABCD, 3, 1, 0, 32'h2000, 4'b1100, 32'hABCD_ABCD, 0);
    do_access(0, 1, 3'b000, 32'h2001, 32'h0000_005A, 0, 2, 0, 32'h2000, 4'b0010, 32'h5A5A_5A5A, 0);
    // LH upper half with gnt and rvalid together; LHU lower half
    do_access(1, 0, 3'b001, 32'h5002, 0, 2, 0, 32'h8001_1234, 32'h5000, 4'hF, 0, 32'hFFFF_8001);
    do_access(1, 0, 3'b101, 32'h5000, 0, 0, 2, 32'h8001_9234, 32'h5000, 4'hF, 0, 32'h0000_9234);

    // Misaligned LW and SH: no bus activity, one-cycle pulse
    mem_rmem = 1'b1; mem_funct3 = 3'b010; mem_addr = 32'h3001;
    #1;
    chk("mis_lw_pulse", misalign, 1);
    chk("mis_lw_stall", stall_req, 0);
    chk("mis_lw_req", bus_req, 0);
    clear_inputs();
    tick();
    chk("mis_after_pulse", misalign, 0);
    chk("mis_after_req", bus_req, 0);
    mem_wmem = 1'b1; mem_funct3 = 3'b001; mem_addr = 32'h2001;
    #1;
    chk("mis_sh_pulse", misalign, 1);
    chk("mis_sh_stall", stall_req, 0);
    clear_inputs();
    tick();
    chk("mis_sh_idle_req", bus_req, 0);

    // Timeout: grant on first cycle, rvalid never comes
    mem_rmem = 1'b1; mem_funct3 = 3'b010; mem_addr = 32'h6000;
    tick();
    for (int c = 1; c <= 8; c++) begin
      chk("tmo_err", bus_err, (c == 8));
      chk("tmo_stall", stall_req, 1);
      bus_gnt = (c == 1);
      tick();
    end
    bus_gnt = 1'b0;
    exp_rd = '0;
    chk("tmo_done_err", bus_err, 0);
    chk("tmo_done_rdata", mem_rdata, exp_rd);
    chk("tmo_done_stall", stall_req, 0);
    chk("tmo_done_req", bus_req, 0);
    clear_inputs();
    tick();
    chk("tmo_idle_req", bus_req, 0);
    do_access(1, 0, 3'b010, 32'h7000, 0, 0, 1, 32'h1234_5678, 32'h7000, 4'hF, 0, 32'h1234_5678);

    // Reset while waiting for the response
    mem_rmem = 1'b1; mem_funct3 = 3'b010; mem_addr = 32'h7008;
    tick();
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    chk("pre_rst_wait_stall", stall_req, 1);
    rst = 1'b1;
    clear_inputs();
    #1;
    exp_rd = '0;
    chk("rst_wait_req", bus_req, 0);
    chk("rst_wait_rdata", mem_rdata, exp_rd);
    chk("rst_wait_stall", stall_req, 0);
    chk("rst_wait_addr", bus_addr, 0);
    tick();
    rst = 1'b0;
    bus_rdata = 32'hFFFF_FFFF;
    bus_rvalid = 1'b1;
    tick();
    bus_rvalid = 1'b0;
    chk("late_rvalid_rdata", mem_rdata, exp_rd);
    chk("late_rvalid_req", bus_req, 0);
    chk("late_rvalid_stall", stall_req, 0);
    chk("late_rvalid_err", bus_err, 0);

    // Back-to-back LW then SW with rmem and wmem both high
    do_access(1, 0, 3'b010, 32'h4000, 0, 0, 1, 32'hCAFE_F00D, 32'h4000, 4'hF, 0, 32'hCAFE_F00D);
    do_access(1, 1, 3'b010, 32'h4004, 32'h1122_3344, 1, 1, 32'h0BAD_0BAD, 32'h4004, 4'hF, 32'h1122_3344, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_mem.md
Name: lsu_mem

Overview:
- Load/store unit in the MEM stage. Consumes the EX/MEM load/store controls and issues a single-outstanding request on the data-memory bus.
- Formats returned load data (byte-lane select, sign/zero extension) into the mem_rdata value captured by the MEM/WB register.
- Stalls the pipeline through stall_req while an access is in flight.
- Flags misaligned accesses and bus timeouts.

Parameters:
- ADDR_W, 32, address width
- TIMEOUT, 255, max cycles in REQ+WAIT before bus_err; minimum 2

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- mem_rmem  in  1  load request from EX/MEM
- mem_wmem  in  1  store request from EX/MEM
- mem_funct3  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU (stores use [1:0])
- mem_addr  in  ADDR_W  byte address
- mem_wdata  in  32  store data, LSB-justified
- mem_rdata  out  32  formatted load result
- stall_req  out  1  hold request to the hazard unit (drives hold[1])
- misalign  out  1  one-cycle misaligned-access pulse
- bus_err  out  1  one-cycle timeout pulse
- bus_req  out  1  bus request
- bus_we  out  1  1 = write
- bus_addr  out  ADDR_W  word-aligned address, [1:0] = 0
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-replicated store data
- bus_gnt  in  1  request accepted
- bus_rvalid  in  1  response (load data or store ack)
- bus_rdata  in  32  load data word

Behaviour:
- Reset (async, immediate):
  - state = IDLE, timeout counter = 0.
  - bus_req, misalign, bus_err = 0; mem_rdata = 0; bus_addr/be/wdata/we = 0.
  - Reset mid-transaction abandons it; late bus_rvalid after reset is ignored in IDLE.
- FSM IDLE -> REQ -> WAIT -> DONE -> IDLE.
- IDLE:
  - If mem_wmem or mem_rmem and access is aligned: latch bus_addr, bus_we, bus_be, bus_wdata, funct3, addr[1:0]; go to REQ. stall_req = 1 this cycle (combinational from inputs).
  - Both rmem and wmem high: the store wins.
  - Misaligned access (LH/LHU/SH with addr[0]; LW/SW with addr[1:0] != 0): no bus access; misalign = 1 for one cycle; stall_req = 0; stay in IDLE.
  - Reserved funct3 (011, 110, 111) executes as a word access.
- REQ:
  - bus_req = 1; addr/we/be/wdata held stable until bus_gnt is sampled high, then go to WAIT.
  - bus_rvalid in the same cycle as bus_gnt completes the access directly (go to DONE).
- WAIT:
  - bus_req = 0. On bus_rvalid: for a load, register formatted data into mem_rdata; go to DONE.
- DONE:
  - stall_req = 0 for exactly one cycle so the pipeline advances. Inputs are ignored, which prevents re-issuing the still-present instruction. Next state IDLE.
- stall_req is 1 in REQ and WAIT.
- Timeout:
  - Counter clears on leaving IDLE and increments each REQ/WAIT cycle.
  - At TIMEOUT cycles without completion: bus_err = 1 for one cycle, mem_rdata = 0 for a load, bus_req dropped, go to DONE.
- Minimum latency with gnt in the first REQ cycle and rvalid the next cycle: stall_req high for 3 cycles (IDLE, REQ, WAIT), DONE on the 4th.
- Store lanes:
  - SB: be = 0001 << addr[1:0], wdata = byte replicated x4.
  - SH: be = addr[1] ? 1100 : 0011, wdata = half replicated x2.
  - SW: be = 1111.
- Load format:
  - Select byte rdata[8*a+7:8*a] or half rdata[16*a1+15:16*a1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- mem_rdata changes only on load completion, timeout, or reset; it holds through stores.

Test Plan:
- LB at 0x1003, bus_rdata = 0x80_00_00_00, gnt immediate, rvalid one cycle later -> bus_addr = 0x1000, be = 1111; stall_req high 3 cycles; DONE cycle mem_rdata = 0xFFFFFF80. The same with LBU -> 0x00000080.
- SH at 0x2002, wdata = 0x0000ABCD, gnt delayed 3 cycles -> bus_req held with stable bus_addr = 0x2000, be = 1100, bus_wdata = 0xABCDABCD; mem_rdata unchanged; one DONE cycle.
- LW at 0x3001 -> misalign pulse in the same cycle, no bus_req, stall_req = 0, state stays IDLE.
- LW, gnt given, rvalid never arrives, TIMEOUT = 8 -> bus_err pulse at the 8th REQ/WAIT cycle; mem_rdata = 0; DONE then IDLE; a subsequent LW completes normally.
- rst asserted while in WAIT -> bus_req = 0 and mem_rdata = 0 immediately; a later bus_rvalid causes no state change.
- Back-to-back LW 0x4000 then SW 0x4004 (rmem and wmem both high on the second) -> two distinct bus transactions, second with bus_we = 1 and be = 1111; no re-issue during DONE.
